// File: rtl/max7219_chain_driver.sv
// MAX7219 cascade driver: power-on init, snapshot refresh, pending queue.
// Ports: i_clk/i_reset_n, i_update_stb+i_digits+i_intensity in;
//        o_serial_dout/clk/load pins, o_busy, o_init_done out.
module max7219_chain_driver #(
  parameter int N_DEVICES = 1,
  parameter int N_DIGITS  = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_update_stb,
  input  logic [N_DEVICES*N_DIGITS*8-1:0] i_digits,
  input  logic [3:0]                      i_intensity,
  output logic                            o_serial_dout,
  output logic                            o_serial_clk,
  output logic                            o_serial_load,
  output logic                            o_busy,
  output logic                            o_init_done
);

  localparam int FW = 16 * N_DEVICES;
  localparam int BW = $clog2(FW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SW = N_DEVICES * N_DIGITS * 8;

  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] DIG_LAST = GW'(N_DIGITS - 1);
  localparam logic [7:0]    SCAN     = 8'(N_DIGITS - 1);

  // Snapshot capture is folded into the frame-start edge so frames
  // run back to back; LOAD_SNAP is a reserved encoding, never entered.
  typedef enum logic [2:0] {
    IDLE, INIT, LOAD_SNAP, SHIFT, LATCH, GAP
  } state_t;

  state_t          state;
  logic [FW-1:0]   shreg;
  logic [BW-1:0]   bit_cnt;
  logic [DW-1:0]   div_cnt;
  logic [GW-1:0]   dig;
  logic [2:0]      idx;
  logic            in_init;
  logic            intf;
  logic            pend;
  logic [SW-1:0]   snap;
  logic [3:0]      last_int;

  logic            div_last;
  logic            go;
  logic            start_ref;
  logic            set_done;
  logic            ld_int;
  logic [FW-1:0]   word;
  logic            n_init;
  logic [2:0]      n_idx;
  logic            n_intf;
  logic [GW-1:0]   n_dig;

  // Same 16-bit word to every device in the chain.
  function automatic logic [FW-1:0] bcast(
    input logic [3:0] a,
    input logic [7:0] d
  );
    logic [FW-1:0] w;
    w = '0;
    for (int k = 0; k < N_DEVICES; k++)
      w[k*16 +: 16] = {4'h0, a, d};
    return w;
  endfunction

  // Digit g for every device; device N_DEVICES-1 sits in the top bits
  // so it is shifted out first.
  function automatic logic [FW-1:0] digw(
    input logic [GW-1:0] g,
    input logic [SW-1:0] src
  );
    logic [FW-1:0] w;
    w = '0;
    for (int k = 0; k < N_DEVICES; k++)
      w[k*16 +: 16] = {4'h0, 4'(g) + 4'd1,
                       src[(k*N_DIGITS + int'(g))*8 +: 8]};
    return w;
  endfunction

  function automatic logic [FW-1:0] init_word(
    input logic [2:0] i,
    input logic [3:0] inten
  );
    case (i)
      3'd0:    return bcast(4'hF, 8'h00);
      3'd1:    return bcast(4'h9, 8'h00);
      3'd2:    return bcast(4'hB, SCAN);
      3'd3:    return bcast(4'hA, {4'h0, inten});
      default: return bcast(4'hC, 8'h01);
    endcase
  endfunction

  assign div_last = (div_cnt == DIV_LAST);

  // Frame-boundary sequencer: decides whether a new frame starts
  // this cycle and which word it carries.
  always_comb begin
    go        = 1'b0;
    start_ref = 1'b0;
    set_done  = 1'b0;
    ld_int    = 1'b0;
    word      = '0;
    n_init    = in_init;
    n_idx     = idx;
    n_intf    = intf;
    n_dig     = dig;
    if (state == INIT) begin
      go     = 1'b1;
      word   = init_word(3'd0, i_intensity);
      n_init = 1'b1;
      n_idx  = 3'd0;
      n_intf = 1'b0;
      n_dig  = '0;
    end else if (state == IDLE) begin
      start_ref = i_update_stb;
    end else if (state == GAP && div_last) begin
      if (in_init) begin
        if (idx != 3'd4) begin
          go     = 1'b1;
          n_idx  = idx + 3'd1;
          word   = init_word(idx + 3'd1, i_intensity);
          ld_int = (idx == 3'd2);
        end else begin
          set_done  = 1'b1;
          start_ref = pend | i_update_stb;
        end
      end else if (intf) begin
        go     = 1'b1;
        n_intf = 1'b0;
        n_dig  = '0;
        word   = digw('0, snap);
      end else if (dig != DIG_LAST) begin
        go    = 1'b1;
        n_dig = dig + GW'(1);
        word  = digw(dig + GW'(1), snap);
      end else begin
        start_ref = pend | i_update_stb;
      end
    end
    if (start_ref) begin
      go     = 1'b1;
      n_init = 1'b0;
      n_dig  = '0;
      if (i_intensity != last_int) begin
        n_intf = 1'b1;
        ld_int = 1'b1;
        word   = bcast(4'hA, {4'h0, i_intensity});
      end else begin
        n_intf = 1'b0;
        word   = digw('0, i_digits);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= INIT;
      shreg         <= '0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      dig           <= '0;
      idx           <= '0;
      in_init       <= 1'b0;
      intf          <= 1'b0;
      pend          <= 1'b0;
      snap          <= '0;
      last_int      <= '0;
      o_serial_dout <= 1'b0;
      o_serial_clk  <= 1'b0;
      o_serial_load <= 1'b0;
      o_busy        <= 1'b0;
      o_init_done   <= 1'b0;
    end else begin
      if (set_done) o_init_done <= 1'b1;
      if (ld_int)   last_int <= i_intensity;
      if (start_ref) snap <= i_digits;
      if (start_ref)
        pend <= 1'b0;
      else if (i_update_stb && state != IDLE)
        pend <= 1'b1;
      in_init <= n_init;
      idx     <= n_idx;
      intf    <= n_intf;
      dig     <= n_dig;
      if (go) begin
        state         <= SHIFT;
        shreg         <= word;
        o_serial_dout <= word[FW-1];
        o_serial_clk  <= 1'b0;
        o_serial_load <= 1'b0;
        bit_cnt       <= '0;
        div_cnt       <= '0;
        o_busy        <= 1'b1;
      end else begin
        unique case (state)
          IDLE, INIT: begin
          end
          LOAD_SNAP: state <= IDLE;
          SHIFT: begin
            if (!div_last) begin
              div_cnt <= div_cnt + DW'(1);
            end else begin
              div_cnt <= '0;
              if (!o_serial_clk) begin
                o_serial_clk <= 1'b1;
              end else begin
                o_serial_clk <= 1'b0;
                if (bit_cnt == BIT_LAST) begin
                  state         <= LATCH;
                  o_serial_load <= 1'b1;
                  o_serial_dout <= 1'b0;
                end else begin
                  bit_cnt       <= bit_cnt + BW'(1);
                  shreg         <= {shreg[FW-2:0], 1'b0};
                  o_serial_dout <= shreg[FW-2];
                end
              end
            end
          end
          LATCH: begin
            if (!div_last) begin
              div_cnt <= div_cnt + DW'(1);
            end else begin
              div_cnt       <= '0;
              o_serial_load <= 1'b0;
              state         <= GAP;
            end
          end
          GAP: begin
            if (!div_last) begin
              div_cnt <= div_cnt + DW'(1);
            end else begin
              div_cnt <= '0;
              state   <= IDLE;
              o_busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_max7219_chain_driver.sv
// Bench for max7219_chain_driver: mock MAX7219 receivers on two
// configurations (1x8 digits, div 2) and (2x4 digits, div 1).
module tb_max7219_chain_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: 1 device, 8 digits, CLK_DIV 2.
  logic        a_rst = 1'b0;
  logic        a_stb = 1'b0;
  logic [63:0] a_digits = '0;
  logic [3:0]  a_int = 4'h8;
  logic        a_dout, a_sclk, a_load, a_busy, a_done;

  max7219_chain_driver #(
    .N_DEVICES(1), .N_DIGITS(8), .CLK_DIV(2)
  ) u_a (
    .i_clk(clk), .i_reset_n(a_rst), .i_update_stb(a_stb),
    .i_digits(a_digits), .i_intensity(a_int),
    .o_serial_dout(a_dout), .o_serial_clk(a_sclk),
    .o_serial_load(a_load), .o_busy(a_busy),
    .o_init_done(a_done)
  );

  // Instance B: 2 devices, 4 digits, CLK_DIV 1.
  logic        b_rst = 1'b0;
  logic        b_stb = 1'b0;
  logic [63:0] b_digits = '0;
  logic [3:0]  b_int = 4'h5;
  logic        b_dout, b_sclk, b_load, b_busy, b_done;

  max7219_chain_driver #(
    .N_DEVICES(2), .N_DIGITS(4), .CLK_DIV(1)
  ) u_b (
    .i_clk(clk), .i_reset_n(b_rst), .i_update_stb(b_stb),
    .i_digits(b_digits), .i_intensity(b_int),
    .o_serial_dout(b_dout), .o_serial_clk(b_sclk),
    .o_serial_load(b_load), .o_busy(b_busy),
    .o_init_done(b_done)
  );

  // Mock receivers, sampled on the falling system clock edge.
  int          cyc = 0;
  logic        a_sclk_q = 1'b0, a_load_q = 1'b0;
  logic        b_sclk_q = 1'b0, b_load_q = 1'b0;
  logic [15:0] a_sr = '0;
  logic [31:0] b_sr = '0;
  logic [7:0]  a_dig [1:8];
  logic [15:0] a_words [$];
  int          a_stamp [$];
  logic [31:0] b_words [$];
  int          b_stamp [$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (a_sclk && !a_sclk_q) a_sr = {a_sr[14:0], a_dout};
    if (a_load && !a_load_q) begin
      a_words.push_back(a_sr);
      a_stamp.push_back(cyc);
      if (a_sr[11:8] >= 4'd1 && a_sr[11:8] <= 4'd8)
        a_dig[a_sr[11:8]] = a_sr[7:0];
    end
    if (b_sclk && !b_sclk_q) b_sr = {b_sr[30:0], b_dout};
    if (b_load && !b_load_q) begin
      b_words.push_back(b_sr);
      b_stamp.push_back(cyc);
    end
    a_sclk_q = a_sclk;
    a_load_q = a_load;
    b_sclk_q = b_sclk;
    b_load_q = b_load;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_pulse();
    @(posedge clk); #1 a_stb = 1'b1;
    @(posedge clk); #1 a_stb = 1'b0;
  endtask

  task automatic b_pulse();
    @(posedge clk); #1 b_stb = 1'b1;
    @(posedge clk); #1 b_stb = 1'b0;
  endtask

  task automatic a_busy_len(output int n);
    n = 0;
    while (a_busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic b_busy_len(output int n);
    n = 0;
    while (b_busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  logic [15:0] init_a [5];
  logic [15:0] init_b [5];
  int n, n0;

  initial begin
    init_a = '{16'h0F00, 16'h0900, 16'h0B07, 16'h0A08, 16'h0C01};
    init_b = '{16'h0F00, 16'h0900, 16'h0B03, 16'h0A05, 16'h0C01};

    // 1: reset state and power-on init on A.
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_outs",
          {a_dout, a_sclk, a_load, a_busy, a_done}, 0);
    a_rst = 1'b1;
    @(posedge clk); #1;
    check("a_busy_first", a_busy, 1);
    a_busy_len(n);
    check("a_init_len", n, 340);
    check("a_init_done", a_done, 1);
    check("a_init_cnt", a_words.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("a_init_w%0d", i), a_words[i], init_a[i]);
    for (int i = 1; i < 5; i++)
      check($sformatf("a_init_gap%0d", i),
            a_stamp[i] - a_stamp[i-1], 68);

    // 2: refresh with bytes 0x30+d, intensity unchanged.
    for (int d = 0; d < 8; d++) a_digits[d*8 +: 8] = 8'(8'h30 + d);
    n0 = a_words.size();
    a_pulse();
    check("a_ref_busy", a_busy, 1);
    a_busy_len(n);
    check("a_ref_len", n, 544);
    check("a_ref_cnt", a_words.size() - n0, 8);
    check("a_ref_gap", a_stamp[n0+1] - a_stamp[n0], 68);
    for (int d = 0; d < 8; d++)
      check($sformatf("a_dig%0d", d), a_dig[d+1], 8'(8'h30 + d));

    // 3: intensity change adds a 0x0A frame, only once.
    a_int = 4'h3;
    n0 = a_words.size();
    a_pulse();
    a_busy_len(n);
    check("a_int_len", n, 612);
    check("a_int_cnt", a_words.size() - n0, 9);
    check("a_int_w0", a_words[n0], 16'h0A03);
    check("a_int_w1", a_words[n0+1], 16'h0130);
    n0 = a_words.size();
    a_pulse();
    a_busy_len(n);
    check("a_same_len", n, 544);
    check("a_same_cnt", a_words.size() - n0, 8);

    // 4: strobes while busy collapse into one follow-on refresh
    //    that snapshots the digits present at that point.
    n0 = a_words.size();
    a_pulse();
    repeat (100) @(posedge clk);
    a_pulse();
    a_pulse();
    a_pulse();
    a_digits = {8{8'h55}};
    a_busy_len(n);
    check("a_pend_len", n, 1088 - 106);
    check("a_pend_cnt", a_words.size() - n0, 16);
    for (int d = 0; d < 8; d++)
      check($sformatf("a_pend_dig%0d", d), a_dig[d+1], 8'h55);

    // 4b: strobe landing on the final GAP cycle of a sequence.
    a_digits = {8{8'hA7}};
    n0 = a_words.size();
    a_pulse();
    repeat (543) @(posedge clk);
    #1;
    check("a_edge_busy", a_busy, 1);
    a_stb = 1'b1;
    @(posedge clk); #1 a_stb = 1'b0;
    a_busy_len(n);
    check("a_edge_len", n, 544);
    check("a_edge_cnt", a_words.size() - n0, 16);

    // 6: reset mid-shift aborts, then init reruns.
    a_pulse();
    repeat (20) @(posedge clk);
    #3 a_rst = 1'b0;
    #1;
    check("a_abort_outs",
          {a_dout, a_sclk, a_load, a_busy, a_done}, 0);
    n0 = a_words.size();
    repeat (5) @(posedge clk);
    #1;
    check("a_abort_noload", a_words.size(), n0);
    a_rst = 1'b1;
    @(posedge clk); #1;
    check("a_rinit_busy", a_busy, 1);
    a_busy_len(n);
    check("a_rinit_len", n, 340);
    check("a_rinit_cnt", a_words.size() - n0, 5);
    init_a[3] = 16'h0A03;
    for (int i = 0; i < 5; i++)
      if (a_words.size() > n0 + i)
        check($sformatf("a_rinit_w%0d", i),
              a_words[n0+i], init_a[i]);
    check("a_rinit_done", a_done, 1);

    // 5: two-device chain, 4 digits, CLK_DIV 1.
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < 4; d++)
        b_digits[(k*4+d)*8 +: 8] = 8'((k+1)*16 + d);
    @(posedge clk); #1 b_rst = 1'b1;
    @(posedge clk); #1;
    check("b_busy_first", b_busy, 1);
    b_busy_len(n);
    check("b_init_len", n, 330);
    check("b_init_done", b_done, 1);
    check("b_init_cnt", b_words.size(), 5);
    for (int i = 0; i < 5; i++)
      if (b_words.size() > i)
        check($sformatf("b_init_w%0d", i),
              b_words[i], {init_b[i], init_b[i]});
    for (int i = 1; i < 5; i++)
      if (b_stamp.size() > i)
        check($sformatf("b_init_gap%0d", i),
              b_stamp[i] - b_stamp[i-1], 66);
    n0 = b_words.size();
    b_pulse();
    b_busy_len(n);
    check("b_ref_len", n, 264);
    check("b_ref_cnt", b_words.size() - n0, 4);
    for (int d = 0; d < 4; d++)
      if (b_words.size() > n0 + d)
        check($sformatf("b_ref_w%0d", d), b_words[n0+d],
              {4'h0, 4'(d+1), 8'(8'h20 + d),
               4'h0, 4'(d+1), 8'(8'h10 + d)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
